shift_operand_decode: RTL and testbench
=======================================

SHIFT_OPERAND_DECODE -- requirements
Module: shift_operand_decode

Interface
REQ-001 SHALL have parameters FULLW (default 32, datapath width) and WIDTH (default 5, shift-amount width).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-low:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  instruction presented
  in_ready  out  1  block accepts instruction this cycle
  instr  in  32  data-processing instruction word
  rm_data  in  FULLW  Rm value, sampled with instr
  rs_rd_en  out  1  Rs read request, single-cycle pulse
  rs_addr  out  4  Rs register index
  rs_data  in  FULLW  Rs value, valid the cycle after rs_rd_en
  out_valid  out  1  shift operands valid
  out_ready  in  1  shifter stage consumes operands
  shiftin  out  FULLW  operand to shift
  shiftby  out  WIDTH  shift amount
  shiftcode  out  2  LSL=0, LSR=1, ASR=2, ROR=3
  bypass  out  1  result = shiftin unshifted
  zero  out  1  result = 0
  carry_sel  out  2  0=shifter carry, 1=C flag, 2=carry_fix
  carry_fix  out  1  fixed carry value

Function
REQ-003 SHALL implement FSM IDLE, WAIT_RS, HOLD.
REQ-004 in_ready SHALL be 1 only in IDLE with output register empty or being consumed (out_valid=0 or out_ready=1).
REQ-005 Accept = in_valid & in_ready; instr and rm_data SHALL be registered on accept.
REQ-006 Immediate (instr[25]=1): shiftin=zero-extended instr[7:0], shiftcode=ROR, shiftby={instr[11:8],0}; out_valid next cycle (latency 1).
REQ-007 Immediate with instr[11:8]=0: bypass=1, carry_sel=1.
REQ-008 Immediate-shift register (instr[25]=0, instr[4]=0): shiftin=rm_data, shiftcode=instr[6:5], shiftby=instr[11:7], bypass=zero=0, carry_sel=0 except LSL #0: bypass=1, carry_sel=1; latency 1.
REQ-009 Register shift (instr[25]=0, instr[4]=1): on accept SHALL pulse rs_rd_en with rs_addr=instr[11:8], go WAIT_RS; next cycle capture rs_data[7:0] as amt, out_valid following cycle (latency 2).
REQ-010 amt=0: bypass=1, carry_sel=1, any shiftcode.
REQ-011 amt 1..31: shiftby=amt[4:0], shiftcode as encoded, carry_sel=0.
REQ-012 amt=32: LSL -> zero=1, carry_sel=2, carry_fix=Rm[0]; LSR -> shiftby=0 (shift-by-32 encoding), carry_sel=0.
REQ-013 amt>32: LSL/LSR -> zero=1, carry_sel=2, carry_fix=0.
REQ-014 ASR amt>=32: shiftby=0, carry_sel=0.
REQ-015 ROR amt>=32: amt[4:0]=0 -> bypass=1, carry_sel=2, carry_fix=Rm[31]; else shiftby=amt[4:0], carry_sel=0. RRX SHALL never be produced from register shifts.
REQ-016 bypass and zero SHALL be mutually exclusive.
REQ-017 Outputs SHALL hold stable while out_valid=1 and out_ready=0 (state HOLD); clear on handshake unless new result loads same cycle.
REQ-018 Back-to-back 1-cycle instructions SHALL sustain one per cycle when out_ready=1.
REQ-019 in_valid during WAIT_RS/HOLD SHALL be ignored (in_ready=0).

Reset
REQ-020 While rst_n=0: state IDLE, out_valid=0, rs_rd_en=0, all datapath outputs 0, in_ready=0; in_ready SHALL rise the first cycle after release.
REQ-021 Reset mid WAIT_RS SHALL discard pending rs_data with no output.

Structure
REQ-022 FULLW, WIDTH, shift codes, carry_sel encodings SHALL live in the shared defines package.
REQ-023 Amount-classification logic (REQ-010..015) SHALL be one combinational sub-module, shift_amt_classify.

Verification
REQ-024 Imm instr rot=4, imm8=0xFF -> next cycle shiftin=0xFF, ROR, shiftby=8, out_valid=1.
REQ-025 Reg shift LSL, rs_data=32, rm_data=0x0000_0001 -> rs_rd_en pulse, 2 cycles later zero=1, carry_sel=2, carry_fix=1.
REQ-026 Reg shift ROR, rs_data=64, rm_data=0x8000_0000 -> bypass=1, carry_fix=1; rs_data=0 -> bypass=1, carry_sel=1.
REQ-027 out_ready=0 for 3 cycles with valid result -> outputs stable, in_ready=0; release -> next instr accepted same cycle.
REQ-028 Streams of 4 immediate instrs, out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-029 rst_n low in WAIT_RS -> out_valid stays 0, in_ready=1 after release.

Source files
------------

// File: rtl/shift_operand_decode_pkg.sv
// Shared definitions for the shift-operand decode stage: datapath widths,
// shifter operation codes, carry-source selects and the decode FSM states.
package shift_operand_decode_pkg;

  localparam int FULLW = 32;
  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shcode_e;

  typedef enum logic [1:0] {
    CSEL_SHIFTER = 2'd0,
    CSEL_CFLAG   = 2'd1,
    CSEL_FIX     = 2'd2
  } csel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RS = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/shift_amt_classify.sv
// Classifies a register-specified shift amount (Rs[7:0]) into the operand
// controls the barrel shifter understands. Purely combinational.
module shift_amt_classify #(
  parameter int FULLW = shift_operand_decode_pkg::FULLW,
  parameter int WIDTH = shift_operand_decode_pkg::WIDTH
) (
  input  logic [7:0]       amt,
  input  logic [1:0]       code,
  input  logic             rm_lsb,
  input  logic             rm_msb,
  output logic [WIDTH-1:0] shiftby,
  output logic             bypass,
  output logic             zero,
  output logic [1:0]       carry_sel,
  output logic             carry_fix
);
  import shift_operand_decode_pkg::*;

  localparam logic [8:0] FULL9 = 9'(FULLW);

  logic [8:0] amt9;
  assign amt9 = {1'b0, amt};

  // Map the amount range (0, in-range, exactly FULLW, beyond) onto shifter controls
  always_comb begin
    shiftby   = '0;
    bypass    = 1'b0;
    zero      = 1'b0;
    carry_sel = CSEL_SHIFTER;
    carry_fix = 1'b0;
    if (amt == 8'd0) begin
      // No shift: value passes through, carry unchanged; never turns into RRX.
      bypass    = 1'b1;
      carry_sel = CSEL_CFLAG;
    end else if (amt9 < FULL9) begin
      shiftby = amt[WIDTH-1:0];
    end else begin
      unique case (code)
        SH_LSL: begin
          zero      = 1'b1;
          carry_sel = CSEL_FIX;
          carry_fix = (amt9 == FULL9) ? rm_lsb : 1'b0;
        end
        SH_LSR: begin
          // LSR by exactly FULLW reuses the shifter's "#0 means FULLW" encoding.
          if (amt9 != FULL9) begin
            zero      = 1'b1;
            carry_sel = CSEL_FIX;
          end
        end
        SH_ASR: begin
          // ASR #0 encodes ASR by FULLW: result is all sign bits, carry = sign.
          shiftby = '0;
        end
        default: begin
          // ROR wraps; a multiple of FULLW leaves the value intact, carry = bit MSB.
          if (amt[WIDTH-1:0] == '0) begin
            bypass    = 1'b1;
            carry_sel = CSEL_FIX;
            carry_fix = rm_msb;
          end else begin
            shiftby = amt[WIDTH-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_decode.sv
// Decodes the shifter-operand field of a data-processing instruction into
// registered barrel-shifter controls. Immediate and immediate-shift forms
// produce a result one cycle after accept; register-shift forms read Rs and
// produce a result two cycles after accept.
module shift_operand_decode #(
  parameter int FULLW = shift_operand_decode_pkg::FULLW,
  parameter int WIDTH = shift_operand_decode_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [FULLW-1:0] rm_data,
  output logic             rs_rd_en,
  output logic [3:0]       rs_addr,
  input  logic [FULLW-1:0] rs_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FULLW-1:0] shiftin,
  output logic [WIDTH-1:0] shiftby,
  output logic [1:0]       shiftcode,
  output logic             bypass,
  output logic             zero,
  output logic [1:0]       carry_sel,
  output logic             carry_fix
);
  import shift_operand_decode_pkg::*;

  state_e           state;
  logic             run_q;
  logic [FULLW-1:0] rm_q;
  logic [1:0]       code_q;

  logic             accept;
  logic             consume;
  logic             is_regsh;

  logic [FULLW-1:0] d_shiftin;
  logic [WIDTH-1:0] d_shiftby;
  logic [1:0]       d_code;
  logic             d_bypass;
  logic             d_zero;
  logic [1:0]       d_csel;

  logic [WIDTH-1:0] c_shiftby;
  logic             c_bypass;
  logic             c_zero;
  logic [1:0]       c_csel;
  logic             c_cfix;

  logic             unused_bits;
  assign unused_bits = ^{instr[31:26], instr[24:12], instr[3:0], rs_data[FULLW-1:8]};

  // run_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready = run_q && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign is_regsh = !instr[25] && instr[4];
  assign rs_rd_en = accept && is_regsh;
  assign rs_addr  = rs_rd_en ? instr[11:8] : 4'd0;

  // Single-cycle decode of the immediate and immediate-shift operand forms
  always_comb begin
    d_shiftin = rm_data;
    d_shiftby = WIDTH'(instr[11:7]);
    d_code    = instr[6:5];
    d_bypass  = 1'b0;
    d_zero    = 1'b0;
    d_csel    = CSEL_SHIFTER;
    if (instr[25]) begin
      d_shiftin = FULLW'(instr[7:0]);
      d_code    = SH_ROR;
      d_shiftby = WIDTH'({instr[11:8], 1'b0});
      if (instr[11:8] == 4'd0) begin
        d_bypass = 1'b1;
        d_csel   = CSEL_CFLAG;
      end
    end else if ((instr[6:5] == SH_LSL) && (instr[11:7] == 5'd0)) begin
      d_bypass = 1'b1;
      d_csel   = CSEL_CFLAG;
    end
  end

  shift_amt_classify #(
    .FULLW (FULLW),
    .WIDTH (WIDTH)
  ) u_classify (
    .amt       (rs_data[7:0]),
    .code      (code_q),
    .rm_lsb    (rm_q[0]),
    .rm_msb    (rm_q[FULLW-1]),
    .shiftby   (c_shiftby),
    .bypass    (c_bypass),
    .zero      (c_zero),
    .carry_sel (c_csel),
    .carry_fix (c_cfix)
  );

  // Capture Rm and the shift type for the register-shift path (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      rm_q   <= rm_data;
      code_q <= instr[6:5];
    end
  end

  // Control FSM and registered operand outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run_q     <= 1'b0;
      out_valid <= 1'b0;
      shiftin   <= '0;
      shiftby   <= '0;
      shiftcode <= '0;
      bypass    <= 1'b0;
      zero      <= 1'b0;
      carry_sel <= '0;
      carry_fix <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (consume) begin
        out_valid <= 1'b0;
        shiftin   <= '0;
        shiftby   <= '0;
        shiftcode <= '0;
        bypass    <= 1'b0;
        zero      <= 1'b0;
        carry_sel <= '0;
        carry_fix <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_regsh) begin
              state <= ST_WAIT_RS;
            end else begin
              out_valid <= 1'b1;
              shiftin   <= d_shiftin;
              shiftby   <= d_shiftby;
              shiftcode <= d_code;
              bypass    <= d_bypass;
              zero      <= d_zero;
              carry_sel <= d_csel;
              carry_fix <= 1'b0;
            end
          end
        end
        ST_WAIT_RS: begin
          out_valid <= 1'b1;
          shiftin   <= rm_q;
          shiftby   <= c_shiftby;
          shiftcode <= code_q;
          bypass    <= c_bypass;
          zero      <= c_zero;
          carry_sel <= c_csel;
          carry_fix <= c_cfix;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_decode.sv
// Scoreboard bench for shift_operand_decode: expected operands are queued at
// accept and compared when the DUT hands a result to the shifter stage.
module tb_shift_operand_decode;
  localparam int FULLW = 32;
  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, rs_rd_en, out_valid, out_ready;
  logic [31:0]      instr;
  logic [FULLW-1:0] rm_data, rs_data, shiftin;
  logic [3:0]       rs_addr;
  logic [WIDTH-1:0] shiftby;
  logic [1:0]       shiftcode, carry_sel;
  logic             bypass, zero, carry_fix;

  always #5 clk = ~clk;

  shift_operand_decode #(.FULLW(FULLW), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rm_data(rm_data), .rs_rd_en(rs_rd_en), .rs_addr(rs_addr),
    .rs_data(rs_data), .out_valid(out_valid), .out_ready(out_ready),
    .shiftin(shiftin), .shiftby(shiftby), .shiftcode(shiftcode), .bypass(bypass),
    .zero(zero), .carry_sel(carry_sel), .carry_fix(carry_fix)
  );

  typedef struct packed {
    logic [31:0] shiftin;
    logic [4:0]  shiftby;
    logic [1:0]  code;
    logic        bypass;
    logic        zero;
    logic [1:0]  csel;
    logic        cfix;
  } exp_t;

  exp_t q[$];
  int   acc_q[$];
  int   lat_q[$];
  int   hs_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b1;

  logic [31:0] rf [16];
  logic        rd_seen = 1'b0;
  logic [3:0]  addr_seen = 4'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dp_imm(input logic [3:0] rot, input logic [7:0] imm8);
    return {4'hE, 3'b001, 4'h4, 1'b0, 4'h0, 4'h0, rot, imm8};
  endfunction

  function automatic logic [31:0] sh_imm(input logic [4:0] amt, input logic [1:0] code);
    return {4'hE, 3'b000, 4'hD, 1'b0, 4'h0, 4'h1, amt, code, 1'b0, 4'h3};
  endfunction

  function automatic logic [31:0] sh_reg(input logic [3:0] rs, input logic [1:0] code);
    return {4'hE, 3'b000, 4'hD, 1'b0, 4'h0, 4'h1, rs, 1'b0, code, 1'b1, 4'h3};
  endfunction

  // Reference decode written from the operand rules
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] rm, input logic [31:0] rs);
    exp_t e;
    int   amt;
    e = '0;
    if (i[25]) begin
      e.shiftin = {24'd0, i[7:0]};
      e.code    = 2'd3;
      e.shiftby = {i[11:8], 1'b0};
      if (i[11:8] == 4'd0) begin e.bypass = 1'b1; e.csel = 2'd1; end
    end else if (!i[4]) begin
      e.shiftin = rm;
      e.code    = i[6:5];
      e.shiftby = i[11:7];
      if (i[6:5] == 2'd0 && i[11:7] == 5'd0) begin e.bypass = 1'b1; e.csel = 2'd1; end
    end else begin
      amt       = int'(rs[7:0]);
      e.shiftin = rm;
      e.code    = i[6:5];
      if (amt == 0) begin
        e.bypass = 1'b1; e.csel = 2'd1;
      end else if (amt < 32) begin
        e.shiftby = 5'(amt);
      end else begin
        case (i[6:5])
          2'd0: begin e.zero = 1'b1; e.csel = 2'd2; e.cfix = (amt == 32) ? rm[0] : 1'b0; end
          2'd1: if (amt != 32) begin e.zero = 1'b1; e.csel = 2'd2; end
          2'd2: e.shiftby = 5'd0;
          default: begin
            if (amt % 32 == 0) begin e.bypass = 1'b1; e.csel = 2'd2; e.cfix = rm[31]; end
            else e.shiftby = 5'(amt % 32);
          end
        endcase
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register file responder: Rs data appears the cycle after the read request
  always @(negedge clk) begin
    rd_seen   = rs_rd_en;
    addr_seen = rs_addr;
  end
  always @(posedge clk) begin
    #1;
    rs_data = rd_seen ? rf[addr_seen] : $urandom;
  end

  // Output monitor
  exp_t m_e;
  int   m_a, m_l;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(1), 64'(0));
      end else begin
        m_e = q.pop_front();
        m_a = acc_q.pop_front();
        m_l = lat_q.pop_front();
        chk("shiftin", 64'(shiftin), 64'(m_e.shiftin));
        chk("shiftby", 64'(shiftby), 64'(m_e.shiftby));
        chk("shiftcode", 64'(shiftcode), 64'(m_e.code));
        chk("bypass", 64'(bypass), 64'(m_e.bypass));
        chk("zero", 64'(zero), 64'(m_e.zero));
        chk("carry_sel", 64'(carry_sel), 64'(m_e.csel));
        chk("carry_fix", 64'(carry_fix), 64'(m_e.cfix));
        if (lat_chk) chk("latency", 64'(cyc - m_a), 64'(m_l));
        hs_q.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] i, input logic [31:0] rm, output int waited);
    int n;
    n = 0;
    in_valid = 1'b1; instr = i; rm_data = rm;
    @(negedge clk);
    while (!in_ready && n < 40) begin n++; @(negedge clk); end
    waited = n;
    if (!in_ready) begin
      chk("accept_timeout", 64'(0), 64'(1));
    end else begin
      q.push_back(model(i, rm, rf[i[11:8]]));
      acc_q.push_back(cyc);
      lat_q.push_back((!i[25] && i[4]) ? 2 : 1);
      if (!i[25] && i[4]) begin
        chk("rs_rd_en", 64'(rs_rd_en), 64'(1));
        chk("rs_addr", 64'(rs_addr), 64'(i[11:8]));
      end else begin
        chk("rs_rd_en_quiet", 64'(rs_rd_en), 64'(0));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete(); acc_q.delete(); lat_q.delete();
    end
  endtask

  logic [1:0]  rcode [12];
  logic [31:0] rval  [12];
  logic [31:0] rrm   [12];
  logic [4:0]  iamt  [5];
  logic [1:0]  icode [5];

  initial begin
    int w, base;
    in_valid = 1'b0; out_ready = 1'b1; instr = '0; rm_data = '0; rs_data = '0;
    for (int k = 0; k < 16; k++) rf[k] = '0;
    rcode = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1};
    rval  = '{32'd32, 32'd64, 32'd0, 32'd7, 32'd32, 32'd40, 32'd50, 32'd33,
              32'hABCD_0105, 32'd200, 32'd0, 32'd31};
    rrm   = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hF000_000F,
              32'hFFFF_FFFF, 32'h8000_0001, 32'hC000_0001, 32'h0000_00FF, 32'h0000_0001,
              32'h7FFF_FFFF, 32'hDEAD_BEEF};
    iamt  = '{5'd5, 5'd0, 5'd31, 5'd0, 5'd0};
    icode = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_rs_rd_en", 64'(rs_rd_en), 64'(0));
    chk("rst_shiftin", 64'(shiftin), 64'(0));
    chk("rst_ctrl", 64'({shiftby, shiftcode, bypass, zero, carry_sel, carry_fix}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Immediates: rot=4 imm=FF, rot=0, and a mid rotation
    send(dp_imm(4'd4, 8'hFF), $urandom, w);
    send(dp_imm(4'd0, 8'h55), $urandom, w);
    send(dp_imm(4'd15, 8'h81), $urandom, w);
    drain();

    // Immediate-shifted register forms
    for (int k = 0; k < 5; k++) send(sh_imm(iamt[k], icode[k]), $urandom, w);
    drain();

    // Register-specified shifts across the amount classes
    for (int k = 0; k < 12; k++) begin
      rf[k + 1] = rval[k];
      send(sh_reg(4'(k + 1), rcode[k]), rrm[k], w);
    end
    drain();

    // Stream of four immediates must complete on consecutive cycles
    base = hs_q.size();
    for (int k = 0; k < 4; k++) send(dp_imm(4'(k), 8'(8'h10 + k)), $urandom, w);
    drain();
    chk("stream_count", 64'(hs_q.size() - base), 64'(4));
    if (hs_q.size() - base == 4) chk("stream_gap", 64'(hs_q[base + 3] - hs_q[base]), 64'(3));

    // Back-pressure on a one-cycle result, then release with a new instruction
    lat_chk = 1'b0;
    out_ready = 1'b0;
    send(dp_imm(4'd1, 8'h3C), $urandom, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_shiftin", 64'(shiftin), 64'(32'h3C));
      chk("stall_shiftby", 64'(shiftby), 64'(2));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(dp_imm(4'd2, 8'hA5), $urandom, w);
    chk("accept_on_release", 64'(w), 64'(0));
    drain();

    // Back-pressure on a register-shift result with a competing instruction offered
    out_ready = 1'b0;
    rf[13] = 32'd33;
    send(sh_reg(4'd13, 2'd0), 32'h0000_0001, w);
    @(negedge clk);
    chk("wait_rs_in_ready", 64'(in_ready), 64'(0));
    chk("wait_rs_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b1; instr = dp_imm(4'd0, 8'h77); rm_data = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_zero", 64'(zero), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting for Rs drops the pending operation
    rf[14] = 32'd3;
    in_valid = 1'b1; instr = sh_reg(4'd14, 2'd1); rm_data = 32'h0000_00F0;
    @(negedge clk);
    chk("pre_rst_rd_en", 64'(rs_rd_en), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid0", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("postrst_valid1", 64'(out_valid), 64'(0));
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(dp_imm(4'd8, 8'h01), $urandom, w);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
